// File: rtl/gups_pkg.sv
// Shared types and defaults for the GUPS memory arbiter.
// Holds the FSM encoding and the address/data width defaults.
package gups_pkg;

  localparam int GUPS_AW = 64;
  localparam int GUPS_DW = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } gups_state_t;

endpackage

// File: rtl/gups_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
// Wraps modulo N; pick is one-hot, valid flags any request.
module gups_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  int w_idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    w_idx = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (!valid && req[w_idx]) begin
        pick[w_idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gups_arbiter.sv
// Arbitrates GUPS engines onto one memory port, locking the grant
// across a full read-modify-write and counting completed updates.
module gups_arbiter
  import gups_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int AW      = GUPS_AW,
  parameter int DW      = GUPS_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr_count,
  input  logic [N_PORTS-1:0]    p_req,
  input  logic [N_PORTS-1:0]    p_wr,
  input  logic [N_PORTS*AW-1:0] p_addr,
  input  logic [N_PORTS*DW-1:0] p_wdata,
  output logic [N_PORTS-1:0]    p_ready,
  output logic [DW-1:0]         p_rdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic                  mem_ready,
  input  logic [DW-1:0]         mem_rdata,
  output logic [N_PORTS-1:0]    grant,
  output logic                  busy,
  output logic [31:0]           update_count
);

  localparam int PW = $clog2(N_PORTS);

  gups_state_t        r_state;
  logic [N_PORTS-1:0] r_grant;
  logic [PW-1:0]      r_ptr;
  logic [31:0]        r_count;

  logic [N_PORTS-1:0] w_pick;
  logic               w_valid;
  logic [PW-1:0]      w_gidx;
  logic [PW-1:0]      w_nptr;
  logic               w_greq;
  logic               w_gwr;
  logic               w_done;

  // Write-phase requests are never eligible from IDLE.
  gups_rr_pick #(.N(N_PORTS), .PW(PW)) u_pick (
    .req   (p_req & ~p_wr),
    .ptr   (r_ptr),
    .pick  (w_pick),
    .valid (w_valid)
  );

  always_comb begin
    w_gidx    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (r_grant[i]) begin
        w_gidx    = PW'(i);
        mem_addr  = p_addr[i*AW +: AW];
        mem_wdata = p_wdata[i*DW +: DW];
      end
    end
  end

  assign w_greq  = |(r_grant & p_req);
  assign w_gwr   = |(r_grant & p_wr);
  assign w_nptr  = (w_gidx == PW'(N_PORTS-1)) ? '0 : w_gidx + 1'b1;
  assign w_done  = (r_state == ST_WRITE) && w_greq
                   && w_gwr && mem_ready;

  assign mem_req      = w_greq;
  assign mem_wr       = w_gwr;
  assign p_ready      = r_grant & {N_PORTS{mem_ready}};
  assign p_rdata      = mem_rdata;
  assign grant        = r_grant;
  assign busy         = (r_state != ST_IDLE);
  assign update_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && w_valid) begin
            r_grant <= w_pick;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          if (!w_greq) begin
            r_grant <= '0;
            r_ptr   <= w_nptr;
            r_state <= ST_IDLE;
          end else if (mem_ready && !w_gwr) begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!w_greq || w_done) begin
            r_grant <= '0;
            r_ptr   <= w_nptr;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
      if (clr_count)
        r_count <= '0;
      else if (w_done)
        r_count <= r_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gups_arbiter.sv
// Directed bench for gups_arbiter with hand-computed expectations.
module tb_gups_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic            clr_count;
  logic [N-1:0]    p_req;
  logic [N-1:0]    p_wr;
  logic [N*AW-1:0] p_addr;
  logic [N*DW-1:0] p_wdata;
  logic [N-1:0]    p_ready;
  logic [DW-1:0]   p_rdata;
  logic            mem_req;
  logic            mem_wr;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;
  logic [N-1:0]    grant;
  logic            busy;
  logic [31:0]     update_count;

  int n_chk  = 0;
  int n_fail = 0;
  int order[5] = '{0, 1, 2, 3, 0};

  gups_arbiter #(.N_PORTS(N), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .clr_count    (clr_count),
    .p_req        (p_req),
    .p_wr         (p_wr),
    .p_addr       (p_addr),
    .p_wdata      (p_wdata),
    .p_ready      (p_ready),
    .p_rdata      (p_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .grant        (grant),
    .busy         (busy),
    .update_count (update_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; clr_count = 1'b0;
    p_req = '0; p_wr = '0; p_addr = '0; p_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      p_addr[i*AW +: AW]  = 64'hA0 + 64'(i);
      p_wdata[i*DW +: DW] = 64'h11 + 64'(i);
    end
    tick(); tick();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_count", 64'(update_count), 64'h0);
    chk("rst_memreq", 64'(mem_req), 64'h0);
    chk("rst_pready", 64'(p_ready), 64'h0);
    reset = 1'b0;

    // single port-0 read-modify-write
    p_req = 4'b0001;
    tick();
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_busy", 64'(busy), 64'h1);
    chk("t1_memreq", 64'(mem_req), 64'h1);
    chk("t1_addr", mem_addr, 64'hA0);
    chk("t1_memwr_rd", 64'(mem_wr), 64'h0);
    mem_ready = 1'b1; mem_rdata = 64'h10;
    #1;
    chk("t1_rdata", p_rdata, 64'h10);
    chk("t1_pready", 64'(p_ready), 64'h1);
    tick();
    mem_ready = 1'b0; p_wr = 4'b0001;
    #1;
    chk("t1_memwr", 64'(mem_wr), 64'h1);
    chk("t1_wdata", mem_wdata, 64'h11);
    chk("t1_pready_lo", 64'(p_ready), 64'h0);
    mem_ready = 1'b1;
    tick();
    chk("t1_count", 64'(update_count), 64'h1);
    chk("t1_idle", 64'(grant), 64'h0);
    mem_ready = 1'b0;
    tick();
    chk("t1_no_wr_grant", 64'(grant), 64'h0);
    p_req = '0; p_wr = '0;

    // all four ports requesting continuously
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t2_grant%0d", k), 64'(grant),
          64'(4'b0001 << order[k]));
      chk($sformatf("t2_addr%0d", k), mem_addr,
          64'hA0 + 64'(order[k]));
      mem_ready = 1'b1;
      #1;
      chk($sformatf("t2_pready%0d", k), 64'(p_ready),
          64'(4'b0001 << order[k]));
      tick();
      p_wr = 4'b0001 << order[k];
      tick();
      chk($sformatf("t2_count%0d", k), 64'(update_count),
          64'(k + 1));
      chk($sformatf("t2_bubble%0d", k), 64'(grant), 64'h0);
      p_wr = '0; mem_ready = 1'b0;
    end
    chk("t2_count_final", 64'(update_count), 64'd5);

    // port 2 locked while port 1 asks during WRITE (ptr=1)
    p_req = 4'b0100;
    tick();
    chk("t3_grant2", 64'(grant), 64'h4);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; p_req = 4'b0110; p_wr = 4'b0100;
    tick();
    chk("t3_locked", 64'(grant), 64'h4);
    chk("t3_pready_lo", 64'(p_ready), 64'h0);
    mem_ready = 1'b1;
    #1;
    chk("t3_p1_notready", 64'(p_ready), 64'h4);
    chk("t3_wdata", mem_wdata, 64'h13);
    tick();
    chk("t3_count", 64'(update_count), 64'd6);
    chk("t3_idle", 64'(grant), 64'h0);
    mem_ready = 1'b0; p_req = 4'b0010; p_wr = '0;
    tick();
    chk("t3_grant1", 64'(grant), 64'h2);

    // port 1 drops p_req in READ: abort, ptr moves to 2
    p_req = 4'b0000;
    tick();
    chk("t4_idle", 64'(grant), 64'h0);
    chk("t4_busy", 64'(busy), 64'h0);
    chk("t4_count", 64'(update_count), 64'd6);
    p_req = 4'b0011;
    tick();
    chk("t4_ptr_wrap", 64'(grant), 64'h1);
    p_req = 4'b0000;
    tick();
    chk("t4_idle2", 64'(grant), 64'h0);

    // en gating (ptr=1), en=0 mid-transaction, clr with increment
    en = 1'b0; p_req = 4'b1111;
    tick(); tick();
    chk("t5_blocked", 64'(grant), 64'h0);
    en = 1'b1;
    tick();
    chk("t5_grant_ptr", 64'(grant), 64'h2);
    en = 1'b0; mem_ready = 1'b1;
    tick();
    p_wr = 4'b0010;
    #1;
    chk("t5_write_en0", 64'(mem_wr), 64'h1);
    chk("t5_busy_en0", 64'(busy), 64'h1);
    clr_count = 1'b1;
    tick();
    chk("t5_clr_inc", 64'(update_count), 64'h0);
    clr_count = 1'b0; mem_ready = 1'b0; p_wr = '0;
    en = 1'b1; p_req = 4'b0001;

    // reset during WRITE with mem_ready high (ptr=2 -> port 0)
    tick();
    chk("t6_grant0", 64'(grant), 64'h1);
    mem_ready = 1'b1;
    tick();
    p_wr = 4'b0001;
    tick();
    chk("t6_count1", 64'(update_count), 64'h1);
    p_wr = '0; mem_ready = 1'b0;
    tick();
    mem_ready = 1'b1;
    tick();
    p_wr = 4'b0001;
    #1;
    chk("t6_in_write", 64'(mem_wr), 64'h1);
    reset = 1'b1;
    tick();
    chk("t6_busy", 64'(busy), 64'h0);
    chk("t6_grant", 64'(grant), 64'h0);
    chk("t6_count", 64'(update_count), 64'h0);
    chk("t6_memreq", 64'(mem_req), 64'h0);
    chk("t6_pready", 64'(p_ready), 64'h0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
